latch_sync_debounce: RTL
========================

# latch_sync_debounce

Clocked consumer for the level output of the D latch stage. It brings the latch's asynchronous `Q` level into the `clk` domain through a two-flop synchronizer, debounces it with a programmable stability window, and publishes a clean level, one-cycle rise/fall strobes and a saturating edge count. It sits directly downstream of the latch, with the latch `Q` wired to this block's `D_IN`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples needed to accept a new level; legal range 2..255.
- `CNT_W`, default 8: width of the edge counter.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `D_IN`  input  1  asynchronous level from the upstream latch `Q`.
- `clr_cnt`  input  1  synchronous clear of `EDGE_CNT`.
- `Q_STABLE`  output  1  debounced level (registered).
- `RISE`  output  1  one-cycle strobe on an accepted 0->1 transition (registered).
- `FALL`  output  1  one-cycle strobe on an accepted 1->0 transition (registered).
- `BUSY`  output  1  high while a candidate transition is being qualified.
- `EDGE_CNT`  output  CNT_W  count of accepted transitions (both directions), saturating.

## Operation
- Synchronizer: `s1 <= D_IN`, `s2 <= s1`. Only `s2` is used by the FSM.
- Debounce counter `db_cnt` has width clog2(DEBOUNCE_CYCLES+1).
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO, `s2`=1: go to WAIT_HI with `db_cnt` <= 1. Otherwise hold.
  - WAIT_HI, `s2`=1 and `db_cnt`==DEBOUNCE_CYCLES-1: go to STABLE_HI, `Q_STABLE` <= 1, `RISE` <= 1, `db_cnt` <= 0.
  - WAIT_HI, `s2`=1 otherwise: `db_cnt` <= `db_cnt`+1.
  - WAIT_HI, `s2`=0: return to STABLE_LO with `db_cnt` <= 0 and no strobe (glitch rejected).
  - STABLE_HI and WAIT_LO mirror the above with polarity inverted; acceptance drives `FALL` and `Q_STABLE` <= 0.
- `RISE` and `FALL` are 0 in every cycle except the one following an acceptance. They are never high together.
- `BUSY` = (state is WAIT_HI or WAIT_LO), decoded from registered state.
- `EDGE_CNT`:
  - Increments by 1 on each acceptance.
  - Holds at 2^CNT_W-1 and never wraps.
  - `clr_cnt` alone loads 0.
  - `clr_cnt` together with an acceptance in the same cycle loads 1: the clear is applied, then the new edge is counted.
- Reset (`rst`=1 at an edge): `s1`, `s2` = 0; state = STABLE_LO; `db_cnt` = 0; `Q_STABLE`, `RISE`, `FALL`, `BUSY` = 0; `EDGE_CNT` = 0. Reset overrides every other input.

## Timing
- Acceptance latency: if `D_IN` changes and is stable before clk edge 0, the acceptance takes effect at edge DEBOUNCE_CYCLES+1. `Q_STABLE` and the strobe are visible after that edge. With the default, this is edge 5.
- Synchronizer contributes 2 edges. FSM qualification contributes DEBOUNCE_CYCLES-1 further edges after WAIT entry.
- A pulse on `s2` shorter than DEBOUNCE_CYCLES cycles produces no strobe, no count and no `Q_STABLE` change. `BUSY` is high for the pulse length only.
- Reset mid-qualification aborts the candidate: no strobe and no count.
- After reset is released with `D_IN` held at 1, the level is treated as a fresh rise. `RISE` fires at edge DEBOUNCE_CYCLES+1, counting from the first edge with `rst`=0.
- Minimum spacing between accepted transitions is DEBOUNCE_CYCLES cycles.

## Test plan
- Reset release with `D_IN`=0 held, then `D_IN`=1 set before edge 0 (default params) -> `Q_STABLE`=1 and `RISE`=1 for exactly one cycle after edge 5; `EDGE_CNT`=1; `BUSY` high from edge 2 to edge 4.
- 3-cycle high glitch on `D_IN` with DEBOUNCE_CYCLES=4 -> no `RISE`; `Q_STABLE` stays 0; `EDGE_CNT`=0; `BUSY` pulses for 3 cycles.
- Accepted rise, then `D_IN`=0 held -> `FALL` one cycle after edge 5 of the fall; `Q_STABLE`=0; `EDGE_CNT`=2.
- CNT_W=2 with 5 accepted transitions -> `EDGE_CNT` reaches 3 and holds there; then `clr_cnt` asserted in the same cycle as a 6th acceptance -> `EDGE_CNT`=1.
- `rst` asserted while in WAIT_HI with `db_cnt`=2 -> after that edge, all outputs are 0 and no `RISE` appears; if `D_IN` stays 1, `RISE` fires DEBOUNCE_CYCLES+1 edges after release.

Source files
------------

// File: rtl/latch_sync_debounce.sv
// latch_sync_debounce
// Takes the asynchronous Q level of the upstream D latch into the clk domain.
// It uses a two-flop synchronizer and debounces the result with a fixed
// stability window. It publishes a clean level, one-cycle rise/fall strobes
// and a saturating count of accepted transitions.
// dbg_state exposes the qualification FSM so checkers can bind to it.
module latch_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,  // legal range 2..255
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D_IN,
    input  logic             clr_cnt,
    output logic             Q_STABLE,
    output logic             RISE,
    output logic             FALL,
    output logic             BUSY,
    output logic [CNT_W-1:0] EDGE_CNT,
    output logic [1:0]       dbg_state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            s1;
    logic            s2;
    logic            acc_rise;
    logic            acc_fall;

    // Two-flop synchronizer; only s2 is safe to use downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= D_IN;
            s2 <= s1;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= STABLE_LO;
            db_cnt <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // Next-state logic: a candidate level must persist DEBOUNCE_CYCLES
    // consecutive samples. Any sample back at the old level rejects the
    // candidate as a glitch.
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        acc_rise   = 1'b0;
        acc_fall   = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s2) begin
                    state_nxt  = WAIT_HI;
                    db_cnt_nxt = DB_W'(1);
                end
            end
            WAIT_HI: begin
                if (s2) begin
                    if (db_cnt == DB_LAST) begin
                        state_nxt  = STABLE_HI;
                        db_cnt_nxt = '0;
                        acc_rise   = 1'b1;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end else begin
                    state_nxt  = STABLE_LO;
                    db_cnt_nxt = '0;
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_nxt  = WAIT_LO;
                    db_cnt_nxt = DB_W'(1);
                end
            end
            WAIT_LO: begin
                if (!s2) begin
                    if (db_cnt == DB_LAST) begin
                        state_nxt  = STABLE_LO;
                        db_cnt_nxt = '0;
                        acc_fall   = 1'b1;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end else begin
                    state_nxt  = STABLE_HI;
                    db_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = STABLE_LO;
                db_cnt_nxt = '0;
            end
        endcase
    end

    // Registered level and one-cycle strobes, updated only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q_STABLE <= 1'b0;
            RISE     <= 1'b0;
            FALL     <= 1'b0;
        end else begin
            RISE <= acc_rise;
            FALL <= acc_fall;
            if (acc_rise) begin
                Q_STABLE <= 1'b1;
            end else if (acc_fall) begin
                Q_STABLE <= 1'b0;
            end
        end
    end

    // Saturating edge counter; a clear coinciding with an acceptance counts that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            EDGE_CNT <= '0;
        end else if (acc_rise || acc_fall) begin
            if (clr_cnt) begin
                EDGE_CNT <= CNT_W'(1);
            end else if (EDGE_CNT != CNT_MAX) begin
                EDGE_CNT <= EDGE_CNT + CNT_W'(1);
            end
        end else if (clr_cnt) begin
            EDGE_CNT <= '0;
        end
    end

    assign BUSY      = (state == WAIT_HI) || (state == WAIT_LO);
    assign dbg_state = state;

endmodule
